// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 start-lights sequencer.
//   f1_state_t  - sequencer state (IDLE, FILL, HOLD, TIMING)
//   *_DEF       - default parameter values used by f1_start_seq
//   LFSR_SEED   - reset value of the hold-time LFSR (never zero)
//   lfsr_taps() - Fibonacci tap mask for a maximal-length LFSR of width w
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    HOLD   = 2'd2,
    TIMING = 2'd3
  } f1_state_t;

  localparam int NUM_LIGHTS_DEF = 8;
  localparam int TICK_W_DEF     = 16;
  localparam int LFSR_W_DEF     = 7;
  localparam int REACT_W_DEF    = 16;

  localparam logic [31:0] LFSR_SEED = 32'd1;

  // Bit i of the mask is polynomial term x^(i+1); the register shifts left
  // and the XOR of the tapped bits enters at bit 0. Width 7 gives
  // x^7+x^6+1 (bits 6 and 5).
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0003 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/f1_tick_gen.sv
// f1_tick_gen: reloadable down-counter producing the lamp tick.
//   clk, rst - clock, synchronous active-high reset (count -> 0)
//   en       - count while high (FILL and HOLD)
//   load     - force the count to N (entry to FILL)
//   N        - tick period minus 1; sampled on every load/reload
//   tick     - high in any enabled cycle where the count is 0
module f1_tick_gen #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [TICK_W-1:0] N,
  output logic              tick
);

  logic [TICK_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Reloading on the tick cycle itself gives a period of N+1 cycles,
  // so a new N takes effect only at the next reload.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= N;
    else if (tick) cnt <= N;
    else if (en)   cnt <= cnt - TICK_W'(1);
  end

endmodule

// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-lights sequencer with random hold and reaction timer.
//   clk, rst     - clock, synchronous active-high reset
//   N            - tick period minus 1 (clk cycles)
//   trigger      - start request, honoured only in IDLE
//   react        - driver button (level)
//   lights       - lamp drive, bit 0 lights first
//   busy         - high whenever not IDLE
//   lights_out   - one-cycle pulse on entry to TIMING
//   react_valid  - one-cycle pulse when react_time updates
//   react_time   - cycles from lights_out to react
//   jump_start   - one-cycle pulse on early react
//   state        - current FSM state, for debug/checkers
// Build option: define F1_JUMP_START_EN to abort on react during FILL/HOLD;
// otherwise react is ignored outside TIMING and jump_start stays 0.
// Handshake: react_valid and lights_out are strobes with no ready/back-pressure;
// react_time holds its value until the next react_valid.
module f1_start_seq
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = NUM_LIGHTS_DEF,
  parameter int TICK_W     = TICK_W_DEF,
  parameter int LFSR_W     = LFSR_W_DEF,
  parameter int REACT_W    = REACT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TICK_W-1:0]     N,
  input  logic                  trigger,
  input  logic                  react,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic                  lights_out,
  output logic                  react_valid,
  output logic [REACT_W-1:0]    react_time,
  output logic                  jump_start,
  output f1_state_t             state
);

  localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(LFSR_SEED);

  f1_state_t             state_d;
  logic [NUM_LIGHTS-1:0] lights_d, fill_next;
  logic [LFSR_W-1:0]     lfsr, lfsr_d, hold_cnt, hold_d;
  logic [REACT_W-1:0]    react_cnt, react_cnt_d, react_time_d;
  logic                  lights_out_d, react_valid_d, jump_d;
  logic                  tick, tick_en, tick_load;

  assign tick_en   = (state == FILL) || (state == HOLD);
  assign tick_load = (state == IDLE) && trigger;
  assign busy      = (state != IDLE);
  assign fill_next = {lights[NUM_LIGHTS-2:0], 1'b1};
  assign lfsr_d    = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

  f1_tick_gen #(.TICK_W(TICK_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .load (tick_load),
    .N    (N),
    .tick (tick)
  );

  always_comb begin
    state_d       = state;
    lights_d      = lights;
    hold_d        = hold_cnt;
    react_cnt_d   = react_cnt;
    react_time_d  = react_time;
    lights_out_d  = 1'b0;
    react_valid_d = 1'b0;
    jump_d        = 1'b0;
    case (state)
      IDLE: begin
        lights_d = '0;
        if (trigger) state_d = FILL;
      end
      FILL: begin
`ifdef F1_JUMP_START_EN
        if (react) begin
          jump_d   = 1'b1;
          lights_d = '0;
          state_d  = IDLE;
        end else
`endif
        if (tick) begin
          lights_d = fill_next;
          // Hold length is latched from the free-running LFSR the moment
          // the last lamp lights.
          if (&fill_next) begin
            state_d = HOLD;
            hold_d  = lfsr;
          end
        end
      end
      HOLD: begin
`ifdef F1_JUMP_START_EN
        if (react) begin
          jump_d   = 1'b1;
          lights_d = '0;
          state_d  = IDLE;
        end else
`endif
        if (tick) begin
          if (hold_cnt == LFSR_W'(1)) begin
            lights_d     = '0;
            lights_out_d = 1'b1;
            react_cnt_d  = '0;
            state_d      = TIMING;
          end else begin
            hold_d = hold_cnt - LFSR_W'(1);
          end
        end
      end
      TIMING: begin
        if (react_cnt != '1) react_cnt_d = react_cnt + REACT_W'(1);
        if (react) begin
          react_time_d  = react_cnt;
          react_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lights      <= '0;
      lfsr        <= LFSR_INIT;
      hold_cnt    <= '0;
      react_cnt   <= '0;
      react_time  <= '0;
      lights_out  <= 1'b0;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
    end else begin
      state       <= state_d;
      lights      <= lights_d;
      lfsr        <= lfsr_d;
      hold_cnt    <= hold_d;
      react_cnt   <= react_cnt_d;
      react_time  <= react_time_d;
      lights_out  <= lights_out_d;
      react_valid <= react_valid_d;
      jump_start  <= jump_d;
    end
  end

endmodule

// File: tb/tb_f1_start_seq.sv
// tb_f1_start_seq: directed bench for f1_start_seq (8-lamp and 4-lamp builds).
// Honours F1_JUMP_START_EN the same way the design does.
module tb_f1_start_seq;
  import f1_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // non-reset edges since the last reset edge; drives the LFSR model
  int ncyc = 0;
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  // ---------------- DUT: 8 lamps ----------------
  logic [15:0] n8;
  logic        trig8, react8;
  logic [7:0]  lights8;
  logic        busy8, lo8, rv8, js8;
  logic [15:0] rt8;
  f1_state_t   st8;

  f1_start_seq #(.NUM_LIGHTS(8)) dut8 (
    .clk(clk), .rst(rst), .N(n8), .trigger(trig8), .react(react8),
    .lights(lights8), .busy(busy8), .lights_out(lo8), .react_valid(rv8),
    .react_time(rt8), .jump_start(js8), .state(st8)
  );

  // ---------------- DUT: 4 lamps ----------------
  logic [15:0] n4;
  logic        trig4, react4;
  logic [3:0]  lights4;
  logic        busy4, lo4, rv4, js4;
  logic [15:0] rt4;
  f1_state_t   st4;

  f1_start_seq #(.NUM_LIGHTS(4)) dut4 (
    .clk(clk), .rst(rst), .N(n4), .trigger(trig4), .react(react4),
    .lights(lights4), .busy(busy4), .lights_out(lo4), .react_valid(rv4),
    .react_time(rt4), .jump_start(js4), .state(st4)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // x^7+x^6+1, shift left, seed 1, n shifts
  function automatic logic [6:0] lfsr_after(input int n);
    logic [6:0] v;
    v = 7'd1;
    for (int i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int h8, h4, last;

  initial begin
    rst = 1'b1; n8 = 16'd3; trig8 = 1'b0; react8 = 1'b0;
    n4 = 16'd0; trig4 = 1'b0; react4 = 1'b0;
    step(); step(); step();

    // reset values
    check("rst_lights8", 32'(lights8), 32'h0);
    check("rst_busy8", 32'(busy8), 32'h0);
    check("rst_lo8", 32'(lo8), 32'h0);
    check("rst_rv8", 32'(rv8), 32'h0);
    check("rst_rt8", 32'(rt8), 32'h0);
    check("rst_js8", 32'(js8), 32'h0);
    check("rst_state8", 32'(st8), 32'(IDLE));
    check("rst_lights4", 32'(lights4), 32'h0);
    check("rst_busy4", 32'(busy4), 32'h0);
    rst = 1'b0;

    // ---- 8 lamps, N=3: fill ----
    trig8 = 1'b1;
    step();                        // edge 0
    trig8 = 1'b0;
    check("fill8_e0", 32'(lights8), 32'h0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check($sformatf("fill8_e%0d", k), 32'(lights8), 32'((1 << (k / 4)) - 1));
      if (k == 1) check("busy8_e1", 32'(busy8), 32'h1);
    end
    check("hold8_state", 32'(st8), 32'(HOLD));

    // ---- hold: H latched at edge 32 ----
    h8 = int'(lfsr_after(ncyc - 1));
    check("h8_range", 32'(h8 >= 1 && h8 <= 127), 32'h1);
    last = 32 + 4 * h8;
    for (int k = 33; k <= last; k++) begin
      step();
      check($sformatf("hold8_lights_e%0d", k), 32'(lights8), (k == last) ? 32'h0 : 32'hFF);
      check($sformatf("hold8_lo_e%0d", k), 32'(lo8), 32'(k == last));
    end
    check("timing8_state", 32'(st8), 32'(TIMING));

    // ---- react 25 cycles after lights_out ----
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 1) check("lo8_one_cycle", 32'(lo8), 32'h0);
      check($sformatf("rv8_quiet_%0d", i), 32'(rv8), 32'h0);
    end
    react8 = 1'b1;
    step();
    react8 = 1'b0;
    check("rv8_pulse", 32'(rv8), 32'h1);
    check("rt8_25", 32'(rt8), 32'd25);
    check("busy8_done", 32'(busy8), 32'h0);
    check("lights8_done", 32'(lights8), 32'h0);
    step();
    check("rv8_end", 32'(rv8), 32'h0);
    check("rt8_hold", 32'(rt8), 32'd25);

    // ---- 4 lamps, N=0: trigger+react together, retrigger in FILL ----
    trig4 = 1'b1; react4 = 1'b1;
    step();                        // edge 0
    trig4 = 1'b1; react4 = 1'b0;   // trigger repeated during FILL
    check("trig_react_busy4", 32'(busy4), 32'h1);
    check("trig_react_rv4", 32'(rv4), 32'h0);
    check("trig_react_state4", 32'(st4), 32'(FILL));
    check("fill4_e0", 32'(lights4), 32'h0);
    step();
    trig4 = 1'b0;
    check("fill4_e1", 32'(lights4), 32'h1);
    step(); check("fill4_e2", 32'(lights4), 32'h3);
    step(); check("fill4_e3", 32'(lights4), 32'h7);
    step(); check("fill4_e4", 32'(lights4), 32'hF);
    h4 = int'(lfsr_after(ncyc - 1));
    last = 4 + h4;
    for (int k = 5; k <= last; k++) begin
      step();
      check($sformatf("hold4_lo_e%0d", k), 32'(lo4), 32'(k == last));
    end
    check("lights4_out", 32'(lights4), 32'h0);
    // react held high while lights_out is asserted
    react4 = 1'b1;
    step();
    react4 = 1'b0;
    check("rv4_pulse", 32'(rv4), 32'h1);
    check("rt4_zero", 32'(rt4), 32'h0);
    check("busy4_done", 32'(busy4), 32'h0);
    step();
    check("rv4_end", 32'(rv4), 32'h0);

    // ---- early react while lights8 = 0x07 ----
    trig8 = 1'b1;
    step();                        // edge 0
    trig8 = 1'b0;
    for (int k = 1; k <= 12; k++) step();
    check("js_pre_lights8", 32'(lights8), 32'h07);
    react8 = 1'b1;
    step();                        // edge 13
    react8 = 1'b0;
`ifdef F1_JUMP_START_EN
    check("js8_pulse", 32'(js8), 32'h1);
    check("js8_lights", 32'(lights8), 32'h0);
    check("js8_state", 32'(st8), 32'(IDLE));
    check("js8_rt", 32'(rt8), 32'd25);
    step();
    check("js8_end", 32'(js8), 32'h0);
    trig8 = 1'b1;
    step();                        // edge 0
    trig8 = 1'b0;
    for (int k = 1; k <= 32; k++) step();
`else
    check("js8_none", 32'(js8), 32'h0);
    check("js8_lights", 32'(lights8), 32'h07);
    check("js8_busy", 32'(busy8), 32'h1);
    for (int k = 14; k <= 32; k++) begin
      step();
      if (k == 16) check("js8_lights_e16", 32'(lights8), 32'h0F);
    end
`endif
    check("rsthold_pre_lights8", 32'(lights8), 32'hFF);
    check("rsthold_pre_state8", 32'(st8), 32'(HOLD));

    // ---- reset in HOLD, then restart ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsthold_lights8", 32'(lights8), 32'h0);
    check("rsthold_busy8", 32'(busy8), 32'h0);
    check("rsthold_state8", 32'(st8), 32'(IDLE));
    check("rsthold_rt8", 32'(rt8), 32'h0);
    check("rsthold_lo8", 32'(lo8), 32'h0);
    trig8 = 1'b1;
    step();                        // edge 0
    trig8 = 1'b0;
    step(); step(); step();
    check("restart8_e3", 32'(lights8), 32'h0);
    step();
    check("restart8_e4", 32'(lights8), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f1_start_seq.md
Name: f1_start_seq

Overview:
- Parametrised F1 start-lights sequencer.
- On a trigger, it lights NUM_LIGHTS lamps one per tick, then holds them all lit for a pseudo-random number of ticks. It then extinguishes them and measures the driver's reaction time in clock cycles.
- Sits between the tick-rate input N and the lamp/display outputs in the lab top level.
- Generalises the fixed 8-light, free-running fill sequence with: a light-count parameter, a trigger/idle mode, a random hold, and reaction timing.

Parameters:
- NUM_LIGHTS, 8, number of lamps (2..32).
- TICK_W, 16, width of the tick period input N.
- LFSR_W, 7, width of the hold-time LFSR. Hold range is 1..2^LFSR_W-1 ticks.
- REACT_W, 16, width of the reaction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- N  in  TICK_W  tick period minus 1, in clk cycles. Sampled whenever the tick counter reloads.
- trigger  in  1  start request. Honoured only in IDLE.
- react  in  1  driver button, level-sensitive.
- lights  out  NUM_LIGHTS  lamp drive; bit 0 lights first.
- busy  out  1  high in any state other than IDLE.
- lights_out  out  1  one-cycle pulse as the sequence enters TIMING.
- react_valid  out  1  one-cycle pulse when react_time updates.
- react_time  out  REACT_W  cycles from lights_out to react.
- jump_start  out  1  one-cycle pulse on early react (feature-gated).

Behaviour:
- Reset: state IDLE, lights=0, busy=0, all pulses 0, react_time=0, LFSR=seed 1, tick counter=0.
  - Reset mid-sequence aborts immediately to these values.
- Tick generator: active only in FILL and HOLD.
  - Loaded with N on entry to FILL, then decrements every cycle.
  - tick=1 in any cycle where the count is 0; the count then reloads N.
  - Tick period is N+1 cycles; N=0 gives a tick every cycle.
- LFSR: Fibonacci, polynomial x^7+x^6+1 for LFSR_W=7 (tap constants come from the package).
  - Shifts every cycle in all states; never reaches 0.
- State machine: IDLE, FILL, HOLD, TIMING.
  - IDLE: lights=0. trigger=1 -> FILL.
  - FILL: on each tick, lights <= {lights[NUM_LIGHTS-2:0],1'b1}. If the new value is all ones -> HOLD, with hold_cnt <= current LFSR value.
  - HOLD: on each tick, hold_cnt decrements. On the tick where hold_cnt==1: lights <= 0, lights_out=1 for that cycle (registered), react_cnt <= 0, -> TIMING.
  - TIMING: react_cnt increments every cycle and saturates at all ones. On react=1: react_time <= react_cnt, react_valid=1 for one cycle, -> IDLE.
- Timing relations:
  - First lamp lights at N+1 cycles after the trigger edge.
  - All lamps lit at NUM_LIGHTS*(N+1) cycles after the trigger edge.
  - lights_out fires at (NUM_LIGHTS+H)*(N+1) cycles after the trigger edge, where H is the sampled LFSR value.
- Boundary conditions:
  - trigger outside IDLE is ignored.
  - react held high across lights_out: react_time=0, reported the cycle after entry into TIMING.
  - react and trigger in the same IDLE cycle: the trigger is taken; react is ignored.
  - N changing mid-sequence takes effect at the next reload.

Optional Feature:
- Macro: F1_JUMP_START_EN.
- Defined: react=1 in FILL or HOLD gives jump_start=1 for one cycle, lights <= 0, -> IDLE. react_time is unchanged.
- Undefined: react is ignored outside TIMING, and jump_start is tied to 0.

Decomposition:
- Package f1_pkg holds:
  - state enum f1_state_t {IDLE, FILL, HOLD, TIMING};
  - LFSR seed and tap-mask constants;
  - the default parameter values.
- Sub-module f1_tick_gen (inputs clk, rst, en, load, N; output tick) implements the reloadable down-counter.

Test Plan:
- NUM_LIGHTS=8, N=3, trigger pulsed at edge 0 -> lights = 0x01, 0x03, 0x07, … at cycles 4, 8, 12, … and 0xFF at cycle 32; busy=1 from cycle 1.
- Continuing that run, bench model of the LFSR gives H -> lights 0x00 and a lights_out pulse at (8+H)*4. Check H is in 1..127.
- React pulsed 25 cycles after lights_out -> react_valid for one cycle, react_time=25, busy=0 next cycle, lights=0.
- N=0, NUM_LIGHTS=4 -> one lamp per cycle (0x1, 0x3, 0x7, 0xF). A trigger re-asserted during FILL has no effect on timing.
- With F1_JUMP_START_EN, react=1 while lights=0x07 -> jump_start pulse, lights=0, IDLE. Without the macro, the same stimulus leaves the sequence unchanged.
- Assert rst in HOLD -> next cycle all outputs 0 and state IDLE. Then a trigger restarts the fill from 0x01.
